// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter slice:
//   - parity mode encodings (PAR_NONE / PAR_ODD / PAR_EVEN)
//   - transmitter FSM state encoding
//   - calc_div   : clocks per bit, rounded to nearest
//   - cnt_width  : width of a counter that must reach DIV-1
//   - parity_bit : parity bit for a payload word (zero-extended to 9 bits)
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_ODD  = 2'd1;
    localparam logic [1:0] PAR_EVEN = 2'd2;

    // Widest legal payload; narrower words are zero-extended for parity.
    localparam int MAX_DATA_BITS = 9;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Clocks per bit, rounded to the nearest integer.
    function automatic int calc_div(input longint clk_hz, input longint baud);
        return int'((clk_hz + baud / 64'sd2) / baud);
    endfunction

    // Counter width able to hold 0..div-1 (never less than one bit).
    function automatic int cnt_width(input int div);
        return (div > 32'sd1) ? $clog2(div) : 32'sd1;
    endfunction

    // Leading zeros from zero-extension do not change the XOR reduction.
    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                        input logic [1:0]               mode);
        logic p;
        case (mode)
            PAR_ODD:  p = ~^data;
            PAR_EVEN: p = ^data;
            default:  p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered status flags.
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   wr_en/wr_data: push; accepted only if full was low before the edge
//   rd_en/rd_data: pop; rd_data always shows the head word
//   full, empty, count : occupancy (registered)
//   overflow     : sticky, set when a push arrives while full
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic             overflow
);

    localparam logic [AW-1:0] PTR_ONE   = AW'(1'b1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);
    localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             ovf_q, ovf_d;
    logic             wr_acc_s, rd_acc_s;

    // Next-state for pointers, occupancy and flags.
    always_comb begin
        // A push is judged against the pre-edge full flag, so a pop in the
        // same cycle never rescues a push into a full FIFO.
        wr_acc_s = wr_en & ~full_q;
        rd_acc_s = rd_en & ~empty_q;

        if (wr_acc_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_acc_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        full_d  = (count_d == CNT_DEPTH);
        empty_d = (count_d == CNT_ZERO);
        ovf_d   = ovf_q | (wr_en & full_q);
    end

    // Control and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= CNT_ZERO;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage array; contents need no reset because empty gates every read.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data  = mem_q[rd_ptr_q];
    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;
    assign overflow = ovf_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// UART transmitter with internal baud generator and TX FIFO. Queued words
// are sent back-to-back: start bit, DATA_BITS payload (LSB first), optional
// parity bit, STOP_BITS stop bits; every bit lasts DIV clocks.
//   Clk, Reset : rising-edge clock, synchronous active-high reset
//   Wr_en, Data_in : single-cycle push of one word
//   Full, Empty, Count, Overflow : FIFO status (Overflow is sticky)
//   Tx     : serial line, idle high, registered
//   Busy   : transmitter not idle
//   TxDone : one-cycle pulse after the last stop bit of each frame
//   Tick   : one-cycle pulse in the last clock of every bit
// ---------------------------------------------------------------------------
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          Wr_en,
    input  logic [DATA_BITS-1:0]          Data_in,
    output logic                          Full,
    output logic                          Empty,
    output logic [$clog2(FIFO_DEPTH):0]   Count,
    output logic                          Overflow,
    output logic                          Tx,
    output logic                          Busy,
    output logic                          TxDone,
    output logic                          Tick
);

    localparam int DIV   = calc_div(longint'(CLK_FREQ), longint'(BAUD_RATE));
    localparam int CNT_W = cnt_width(DIV);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1'b1);
    localparam logic [1:0]       PAR_MODE  = 2'(PARITY);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    // Parameter legality is checked at elaboration.
    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_fifo: clocks per bit must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_fifo: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end

    tx_state_e            state_q, state_d;
    logic                 tx_q, tx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 par_q, par_d;
    logic                 stop_q, stop_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 tick_q, tick_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pop_s;
    logic [DATA_BITS-1:0] fifo_data_s;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (Clk),
        .reset    (Reset),
        .wr_en    (Wr_en),
        .wr_data  (Data_in),
        .rd_en    (pop_s),
        .rd_data  (fifo_data_s),
        .full     (Full),
        .empty    (Empty),
        .count    (Count),
        .overflow (Overflow)
    );

    // Frame sequencing: next state, line level, shift register and pops.
    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        par_d   = par_q;
        stop_d  = stop_q;
        pop_s   = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!Empty) begin
                    pop_s   = 1'b1;
                    shift_d = fifo_data_s;
                    idx_d   = {IDX_W{1'b0}};
                    par_d   = parity_bit(MAX_DATA_BITS'(fifo_data_s), PAR_MODE);
                    tx_d    = 1'b0;
                    state_d = ST_START;
                end else begin
                    tx_d = 1'b1;
                end
            end
            ST_START: begin
                // Shift right so bit 0 always holds the next payload bit.
                if (tick_q) begin
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_q) begin
                    if (idx_q != IDX_LAST) begin
                        idx_d   = idx_q + IDX_ONE;
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                    end else if (PAR_MODE != PAR_NONE) begin
                        tx_d    = par_q;
                        state_d = ST_PARITY;
                    end else begin
                        tx_d    = 1'b1;
                        stop_d  = 1'b0;
                        state_d = ST_STOP;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (tick_q) begin
                    tx_d    = 1'b1;
                    stop_d  = 1'b0;
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (tick_q) begin
                    if (stop_q != STOP_LAST) begin
                        stop_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                        // Chain straight into the next start bit when data waits.
                        if (!Empty) begin
                            pop_s   = 1'b1;
                            shift_d = fifo_data_s;
                            idx_d   = {IDX_W{1'b0}};
                            par_d   = parity_bit(MAX_DATA_BITS'(fifo_data_s), PAR_MODE);
                            tx_d    = 1'b0;
                            state_d = ST_START;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Baud counter; Tick and Busy are predicted from next state so they come out registered.
    always_comb begin
        if (state_q == ST_IDLE) begin
            cnt_d = CNT_ZERO;
        end else if (tick_q) begin
            cnt_d = CNT_ZERO;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
        tick_d = (state_d != ST_IDLE) && (cnt_d == CNT_MAX);
        busy_d = (state_d != ST_IDLE);
    end

    // Transmitter state registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            tx_q    <= 1'b1;
            shift_q <= {DATA_BITS{1'b0}};
            idx_q   <= {IDX_W{1'b0}};
            par_q   <= 1'b0;
            stop_q  <= 1'b0;
            cnt_q   <= CNT_ZERO;
            tick_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            par_q   <= par_d;
            stop_q  <= stop_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Tx     = tx_q;
    assign Busy   = busy_q;
    assign TxDone = done_q;
    assign Tick   = tick_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
// Drives five frame configurations in parallel (8N1, 8E1, 8O1, 7N2 with a
// 16-deep FIFO, 8N1 with a 4-deep FIFO) from one shared stimulus stream at
// 10 clocks per bit. Each configuration has its own reference: a word queue
// plus a "clocks into frame" counter; the expected line level is the frame
// bit at position t/DIV.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int CLK_HZ = 1000000;
    localparam int BAUD   = 100000;
    localparam int DIV    = 10;
    localparam int NCFG   = 5;

    function automatic int cfg_db(input int i);
        case (i)
            3:       return 7;
            default: return 8;
        endcase
    endfunction

    function automatic int cfg_par(input int i);
        case (i)
            1:       return 2;
            2:       return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int cfg_sb(input int i);
        case (i)
            3:       return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int cfg_dp(input int i);
        case (i)
            4:       return 4;
            default: return 16;
        endcase
    endfunction

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [8:0] wdata;
    bit         chk_en = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (time %0t)", tag, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int DB  = cfg_db(g);
        localparam int PAR = cfg_par(g);
        localparam int SB  = cfg_sb(g);
        localparam int DP  = cfg_dp(g);
        localparam int FL  = 1 + DB + ((PAR != 0) ? 1 : 0) + SB;

        logic                  tx_s, busy_s, done_s, tick_s, full_s, empty_s, ovf_s;
        logic [$clog2(DP):0]   cnt_s;

        uart_tx_fifo #(
            .CLK_FREQ   (CLK_HZ),
            .BAUD_RATE  (BAUD),
            .DATA_BITS  (DB),
            .PARITY     (PAR),
            .STOP_BITS  (SB),
            .FIFO_DEPTH (DP)
        ) u_dut (
            .Clk      (clk),
            .Reset    (rst),
            .Wr_en    (wr_en),
            .Data_in  (wdata[DB-1:0]),
            .Full     (full_s),
            .Empty    (empty_s),
            .Count    (cnt_s),
            .Overflow (ovf_s),
            .Tx       (tx_s),
            .Busy     (busy_s),
            .TxDone   (done_s),
            .Tick     (tick_s)
        );

        logic [DB-1:0] mq[$];
        logic [DB-1:0] w;
        int            t = -1;
        int            n_ones;
        bit            m_done = 1'b0;
        bit            m_ovf  = 1'b0;
        bit            full_pre;
        bit            fbits[12];

        // Reference model: advance one clock using the pre-edge inputs.
        always @(posedge clk) begin
            m_done = 1'b0;
            if (rst) begin
                mq.delete();
                t     = -1;
                m_ovf = 1'b0;
            end else begin
                full_pre = (mq.size() == DP);
                if (t >= 0) begin
                    t = t + 1;
                    if (t == FL * DIV) begin
                        m_done = 1'b1;
                        t      = -1;
                    end
                end
                if (t < 0 && mq.size() != 0) begin
                    w        = mq.pop_front();
                    n_ones   = 0;
                    fbits[0] = 1'b0;
                    for (int i = 0; i < DB; i++) begin
                        fbits[1 + i] = w[i];
                        n_ones += int'(w[i]);
                    end
                    if (PAR == 1) begin
                        fbits[DB + 1] = ((n_ones % 2) == 0);
                    end else if (PAR == 2) begin
                        fbits[DB + 1] = ((n_ones % 2) == 1);
                    end
                    for (int i = FL - SB; i < FL; i++) begin
                        fbits[i] = 1'b1;
                    end
                    t = 0;
                end
                if (wr_en) begin
                    if (full_pre) begin
                        m_ovf = 1'b1;
                    end else begin
                        mq.push_back(wdata[DB-1:0]);
                    end
                end
            end
        end

        // Compare every DUT output against the model away from the active edge.
        always @(negedge clk) begin
            if (chk_en) begin
                check_eq($sformatf("c%0d.tx", g), 32'(tx_s),
                         (t < 0) ? 32'd1 : 32'(fbits[t / DIV]));
                check_eq($sformatf("c%0d.busy", g), 32'(busy_s), 32'(t >= 0));
                check_eq($sformatf("c%0d.txdone", g), 32'(done_s), 32'(m_done));
                check_eq($sformatf("c%0d.tick", g), 32'(tick_s),
                         32'((t >= 0) && ((t % DIV) == DIV - 1)));
                check_eq($sformatf("c%0d.count", g), 32'(cnt_s), 32'(mq.size()));
                check_eq($sformatf("c%0d.empty", g), 32'(empty_s), 32'(mq.size() == 0));
                check_eq($sformatf("c%0d.full", g), 32'(full_s), 32'(mq.size() == DP));
                check_eq($sformatf("c%0d.overflow", g), 32'(ovf_s), 32'(m_ovf));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [8:0] d);
        wr_en = 1'b1;
        wdata = d;
        @(negedge clk);
        wr_en = 1'b0;
        wdata = 9'($urandom);
    endtask

    // Stimulus sequence, all inputs changed on the falling edge.
    initial begin
        rst   = 1'b1;
        wr_en = 1'b0;
        wdata = 9'd0;
        idle(3);
        rst    = 1'b0;
        chk_en = 1'b1;
        idle(4);

        // Single frame of 0xA5, then 0x07 for the parity configurations.
        push(9'h0A5);
        idle(150);
        push(9'h007);
        idle(150);

        // Three words on consecutive cycles: frames must chain with no gap.
        push(9'h011);
        push(9'h022);
        push(9'h033);
        idle(400);

        // Six back-to-back writes overflow the 4-deep FIFO.
        for (int i = 0; i < 6; i++) begin
            push(9'($urandom));
        end
        idle(800);

        // Reset in the middle of a frame with words still queued.
        push(9'h1C3);
        push(9'h05A);
        push(9'h0F0);
        idle(33);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(200);

        // Hold Wr_en high so pushes collide with pops while full.
        wr_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            wdata = 9'($urandom);
            @(negedge clk);
        end
        wr_en = 1'b0;
        idle(2100);

        // Sparse random traffic with rare resets.
        for (int i = 0; i < 3000; i++) begin
            wr_en = ($urandom_range(0, 15) == 0);
            wdata = 9'($urandom);
            rst   = ($urandom_range(0, 999) == 0);
            @(negedge clk);
        end
        wr_en = 1'b0;
        rst   = 1'b0;
        idle(2100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an internal baud generator and a TX FIFO.
- Frame format is configurable: data width, parity, stop bits.
- Host pushes words with a single-cycle strobe; the block serialises them back-to-back with no idle gap while the FIFO holds data.
- Replaces the fixed 8N1 transmitter + free-running baud generator pair used for serial loopback tests.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD_RATE, 115200, line rate in bit/s; DIV = (CLK_FREQ + BAUD_RATE/2) / BAUD_RATE clocks per bit; elaboration error if DIV < 2
DATA_BITS, 8, payload bits per frame, legal 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, legal 1 or 2
FIFO_DEPTH, 16, TX FIFO entries, power of 2, >= 2

Ports:
Clk  in  1  system clock, all logic on rising edge
Reset  in  1  synchronous, active-high reset
Wr_en  in  1  push Data_in into FIFO this cycle
Data_in  in  DATA_BITS  word to transmit, LSB sent first
Full  out  1  FIFO holds FIFO_DEPTH words
Empty  out  1  FIFO holds 0 words
Count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
Overflow  out  1  sticky: a write was dropped because the FIFO was full
Tx  out  1  serial line, idle high, registered
Busy  out  1  high in any state other than IDLE
TxDone  out  1  one-cycle pulse in the cycle after the last stop bit completes
Tick  out  1  one-cycle pulse at each bit boundary, for debug

Behaviour:
- Reset: Tx=1, Busy=0, TxDone=0, Tick=0, Overflow=0, Empty=1, Full=0, Count=0; FIFO pointers cleared; FSM to IDLE; baud counter to 0.
- Reset mid-frame: frame abandoned, no TxDone; Tx=1 in the cycle after Reset is sampled; all queued words discarded.
- FIFO:
  - Write accepted when Wr_en=1 and Full=0, where Full is the pre-edge value.
  - Wr_en while Full=1 drops the word and sets Overflow, even if a pop occurs in the same cycle.
  - Simultaneous accepted write and pop: Count unchanged, pointers both advance.
  - Pointers wrap modulo FIFO_DEPTH.
- Baud counter:
  - Held at 0 in IDLE; counts 0..DIV-1 in all other states.
  - Tick=1 when counter = DIV-1; counter then wraps to 0.
  - Every bit, start bit included, lasts exactly DIV clocks.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - If Empty=0: pop the head word into the shift register, set bit index 0, latch the parity bit, drive Tx<=0, go to START.
  - Else hold Tx=1.
  - Latency: Wr_en sampled at edge k into an empty FIFO → pop at edge k+1 → Tx low from edge k+1.
- START: on Tick → Tx<=data[0], go to DATA.
- DATA: on Tick:
  - If index < DATA_BITS-1: index+1, Tx<=next bit.
  - Else if PARITY != 0: Tx<=parity, go to PARITY.
  - Else: Tx<=1, go to STOP.
- Parity bit:
  - odd: p = ~^data (total ones including p is odd).
  - even: p = ^data.
  - Computed from the popped word.
- PARITY: on Tick → Tx<=1, go to STOP.
- STOP: lasts STOP_BITS×DIV clocks via a stop-bit counter. On the final Tick:
  - Pulse TxDone.
  - If Empty=0: pop the next word, Tx<=0, go to START (zero idle gap).
  - Else: go to IDLE with Tx=1.
- Frame length: (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × DIV clocks.
- Data_in changes after acceptance never affect queued or in-flight words.

Decomposition:
- Package uart_pkg:
  - Parity constants PAR_NONE/PAR_ODD/PAR_EVEN.
  - FSM state encoding.
  - Divisor function calc_div(clk, baud).
  - Width helper for the baud counter, $clog2(DIV).
- One sub-module: sync_fifo (parametrised width/depth; wr/rd, full/empty/count, pre-edge full check).
- The FSM, baud counter and shift register live in uart_tx_fifo.

Test Plan:
- Use CLK_FREQ=1000000, BAUD_RATE=100000 (DIV=10) for all scenarios.
1. 8N1, write 0xA5 at edge 0 → Tx low edges 1..10, then bits 1,0,1,0,0,1,0,1 for 10 clocks each, stop high 10 clocks; TxDone pulse at edge 101; Busy low after.
2. 8E1 with 0x07 → parity bit 1; 8O1 with 0x07 → parity bit 0; frame = 110 clocks.
3. 7N2, three words written on consecutive cycles (0x11, 0x22, 0x33) → three frames of 100 clocks, contiguous with no idle high gap between stop and next start; exactly three TxDone pulses.
4. FIFO_DEPTH=4, 6 writes on consecutive cycles from idle → first word pops at edge 1, next 4 queued; 6th write dropped; Overflow=1; Count peaks at 4; only 5 frames transmitted.
5. Reset asserted 35 clocks into a frame with 2 words queued → Tx=1, Count=0, Busy=0 next cycle; no TxDone; Tx stays high thereafter.
6. Write when Full and pop in the same cycle (stop-bit end) → write dropped, Overflow set, Count decremented by 1.
